// File: rtl/shift_pkg.sv
// Shared constants for the shift/rotate execute path: widths and opcodes.
package shift_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned REG_W  = 3;

  // Codes 3'b101..3'b111 are unused and pass data through unchanged.
  typedef enum logic [2:0] {
    OP_ROL = 3'b000,
    OP_SLL = 3'b001,
    OP_ROR = 3'b010,
    OP_SRL = 3'b011,
    OP_SRA = 3'b100
  } shift_op_e;

endpackage

// File: rtl/shifter.sv
// Combinational 16-bit barrel shifter: rotates, logical shifts, arithmetic right shift.
module shifter
  import shift_pkg::*;
(
  input  logic [DATA_W-1:0] In,
  input  logic [CNT_W-1:0]  Cnt,
  input  logic [2:0]        Op,
  output logic [DATA_W-1:0] Out
);

  // Complement shift amount for rotates; Cnt=0 gives a full-width shift, i.e. zero.
  localparam logic [CNT_W:0] FULL = (CNT_W + 1)'(DATA_W);

  logic [CNT_W:0] rcnt;

  assign rcnt = FULL - {1'b0, Cnt};

  // Select the shifted/rotated form of the operand by opcode
  always_comb begin
    Out = In;
    case (Op)
      OP_ROL:  Out = (In << Cnt) | (In >> rcnt);
      OP_SLL:  Out = In << Cnt;
      OP_ROR:  Out = (In >> Cnt) | (In << rcnt);
      OP_SRL:  Out = In >> Cnt;
      OP_SRA:  Out = $signed(In) >>> Cnt;
      default: Out = In;
    endcase
  end

endmodule

// File: rtl/shift_ex_pipe.sv
// Two-stage shift/rotate execute pipe: S1 operand register, shared shifter, S2 result register.
// Optional result forwarding from S2 into the shifter input: define SHIFT_EX_FWD_EN.
module shift_ex_pipe
  import shift_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CNT_W-1:0]  in_cnt,
  input  logic [REG_W-1:0]  in_rs,
  input  logic              in_rs_vld,
  input  logic [REG_W-1:0]  in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [REG_W-1:0]  out_rd
);

  logic              s1_valid;
  logic [2:0]        s1_op;
  logic [DATA_W-1:0] s1_data;
  logic [CNT_W-1:0]  s1_cnt;
  logic [REG_W-1:0]  s1_rd;
  logic              s2_valid;
  logic              s1_ready;
  logic              s2_ready;
  logic [DATA_W-1:0] shift_in;
  logic [DATA_W-1:0] shift_out;

  assign s2_ready  = !s2_valid || out_ready;
  assign s1_ready  = !s1_valid || s2_ready;
  assign in_ready  = s1_ready && !flush;
  assign out_valid = s2_valid;

`ifdef SHIFT_EX_FWD_EN
  logic [REG_W-1:0] s1_rs;
  logic             s1_rs_vld;

  // Forward the immediately preceding result when it writes our source register
  always_comb begin
    shift_in = s1_data;
    if (s1_valid && s1_rs_vld && s2_valid && (s1_rs == out_rd))
      shift_in = out_data;
  end

  // Source register tag for the forwarding compare
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_rs     <= '0;
      s1_rs_vld <= 1'b0;
    end else if (!flush && s1_ready && in_valid) begin
      s1_rs     <= in_rs;
      s1_rs_vld <= in_rs_vld;
    end
  end
`else
  logic unused_fwd_fields;

  assign unused_fwd_fields = ^{in_rs, in_rs_vld};

  // Without forwarding the shifter always sees the latched operand
  always_comb begin
    shift_in = s1_data;
  end
`endif

  shifter u_shifter (
    .In  (shift_in),
    .Cnt (s1_cnt),
    .Op  (s1_op),
    .Out (shift_out)
  );

  // S1 operand register: load on accept, cleared by reset or flush
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_data  <= '0;
      s1_cnt   <= '0;
      s1_rd    <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (s1_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op   <= in_op;
        s1_data <= in_data;
        s1_cnt  <= in_cnt;
        s1_rd   <= in_rd;
      end
    end
  end

  // S2 result register: capture shifter output on transfer, hold while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      out_data <= '0;
      out_rd   <= '0;
    end else if (flush) begin
      s2_valid <= 1'b0;
    end else if (s2_ready) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= shift_out;
        out_rd   <= s1_rd;
      end
    end
  end

endmodule

// File: tb/tb_shift_ex_pipe.sv
// Self-checking bench for shift_ex_pipe: queue-based reference model plus directed cases.
module tb_shift_ex_pipe;
  import shift_pkg::*;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [15:0] in_data;
  logic [3:0]  in_cnt;
  logic [2:0]  in_rs;
  logic        in_rs_vld;
  logic [2:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [2:0]  out_rd;

  int checks = 0;
  int errors = 0;

  shift_ex_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_data   (in_data),
    .in_cnt    (in_cnt),
    .in_rs     (in_rs),
    .in_rs_vld (in_rs_vld),
    .in_rd     (in_rd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_rd    (out_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference shift: apply the operation one bit position at a time
  function automatic logic [15:0] ref_shift(input logic [2:0] op, input logic [15:0] d,
                                            input logic [3:0] c);
    logic [15:0] r;
    r = d;
    for (int i = 0; i < int'(c); i++) begin
      case (op)
        3'd0: r = {r[14:0], r[15]};
        3'd1: r = {r[14:0], 1'b0};
        3'd2: r = {r[0], r[15:1]};
        3'd3: r = {1'b0, r[15:1]};
        3'd4: r = {r[15], r[15:1]};
        default: r = r;
      endcase
    end
    return r;
  endfunction

  // Model: ordered list of in-flight ops; st2 marks the one sitting in the result slot
  typedef struct {
    logic [2:0]  op;
    logic [15:0] data;
    logic [3:0]  cnt;
    logic [2:0]  rs;
    logic        rs_vld;
    logic [2:0]  rd;
    logic [15:0] res;
    bit          st2;
  } item_t;

  item_t       q[$];
  logic [15:0] m_out_data;
  logic [2:0]  m_out_rd;
  bit          m_live = 0;

  // Two ops in flight is the capacity; only then can a stalled output block input
  function automatic logic m_in_ready();
    return !flush && !(q.size() == 2 && !out_ready);
  endfunction

  function automatic logic m_out_valid();
    return q.size() > 0 && q[0].st2;
  endfunction

  bit          acc;
  bit          s2occ;
  int          idx;
  item_t       it;
  item_t       nw;
  logic [15:0] src;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_out_data = '0;
      m_out_rd   = '0;
      m_live     = 1;
    end else if (flush) begin
      q.delete();
    end else begin
      acc   = in_valid && m_in_ready();
      s2occ = m_out_valid();
      if (!s2occ || out_ready) begin
        idx = s2occ ? 1 : 0;
        if (q.size() > idx) begin
          it  = q[idx];
          src = it.data;
`ifdef SHIFT_EX_FWD_EN
          if (s2occ && it.rs_vld && q[0].rd == it.rs) src = q[0].res;
`endif
          it.res     = ref_shift(it.op, src, it.cnt);
          it.st2     = 1;
          q[idx]     = it;
          m_out_data = it.res;
          m_out_rd   = it.rd;
        end
        if (s2occ) void'(q.pop_front());
      end
      if (acc) begin
        nw.op = in_op; nw.data = in_data; nw.cnt = in_cnt;
        nw.rs = in_rs; nw.rs_vld = in_rs_vld; nw.rd = in_rd;
        nw.res = '0; nw.st2 = 0;
        q.push_back(nw);
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (m_live) begin
      chk("out_valid", {31'b0, out_valid}, {31'b0, m_out_valid()});
      chk("in_ready",  {31'b0, in_ready},  {31'b0, m_in_ready()});
      chk("out_data",  {16'b0, out_data},  {16'b0, m_out_data});
      chk("out_rd",    {29'b0, out_rd},    {29'b0, m_out_rd});
    end
  end

  task automatic drive_op(input logic [2:0] op, input logic [15:0] d, input logic [3:0] c,
                          input logic [2:0] rs, input logic rsv, input logic [2:0] rd);
    in_valid = 1'b1; in_op = op; in_data = d; in_cnt = c;
    in_rs = rs; in_rs_vld = rsv; in_rd = rd;
  endtask

  task automatic basic(input string nm, input logic [2:0] op, input logic [15:0] d,
                       input logic [3:0] c, input logic [15:0] exp);
    @(negedge clk); #1 drive_op(op, d, c, 3'd0, 1'b0, 3'd5);
    @(negedge clk);
    chk({nm, "_lat1"}, {31'b0, out_valid}, 32'd0);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_valid"}, {31'b0, out_valid}, 32'd1);
    chk({nm, "_data"}, {16'b0, out_data}, {16'b0, exp});
    chk({nm, "_rd"}, {29'b0, out_rd}, 32'd5);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_op = '0; in_data = '0; in_cnt = '0; in_rs = '0; in_rs_vld = 1'b0; in_rd = '0;

    chk("pin_sll15", {16'b0, ref_shift(3'd1, 16'h0001, 4'd15)}, 32'h8000);
    chk("pin_sra4",  {16'b0, ref_shift(3'd4, 16'h8000, 4'd4)},  32'hF800);
    chk("pin_ror1",  {16'b0, ref_shift(3'd2, 16'h0001, 4'd1)},  32'h8000);
    chk("pin_rol4",  {16'b0, ref_shift(3'd0, 16'h8421, 4'd4)},  32'h4218);

    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_data",  {16'b0, out_data},  32'd0);
    chk("rst_out_rd",    {29'b0, out_rd},    32'd0);
    chk("rst_in_ready",  {31'b0, in_ready},  32'd1);

    basic("sll15", OP_SLL, 16'h0001, 4'd15, 16'h8000);
    basic("sra4",  OP_SRA, 16'h8000, 4'd4,  16'hF800);
    basic("srl4",  OP_SRL, 16'h8000, 4'd4,  16'h0800);
    basic("ror1",  OP_ROR, 16'h0001, 4'd1,  16'h8000);
    basic("op7",   3'b111, 16'hA5C3, 4'd9,  16'hA5C3);
    basic("sra0",  OP_SRA, 16'hA5C3, 4'd0,  16'hA5C3);
    basic("rol0",  OP_ROL, 16'hA5C3, 4'd0,  16'hA5C3);

    // Back-to-back dependency: B reads A's destination register
    @(negedge clk); #1 drive_op(OP_SLL, 16'h0003, 4'd2, 3'd0, 1'b0, 3'd3);
    @(negedge clk); #1 drive_op(OP_ROL, 16'h00F0, 4'd1, 3'd3, 1'b1, 3'd4);
    @(negedge clk);
    chk("fwd_a", {16'b0, out_data}, 32'h000C);
    #1 in_valid = 1'b0; in_rs_vld = 1'b0;
    @(negedge clk);
`ifdef SHIFT_EX_FWD_EN
    chk("fwd_b", {16'b0, out_data}, 32'h0018);
`else
    chk("fwd_b", {16'b0, out_data}, 32'h01E0);
`endif

    // Backpressure: three ops against a stalled output
    @(negedge clk); #1 out_ready = 1'b0; drive_op(OP_SLL, 16'h0001, 4'd1, 3'd0, 1'b0, 3'd1);
    @(negedge clk); #1 drive_op(OP_SLL, 16'h0001, 4'd2, 3'd0, 1'b0, 3'd2);
    @(negedge clk); #1 drive_op(OP_SLL, 16'h0001, 4'd3, 3'd0, 1'b0, 3'd3);
    #1 chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    chk("bp_hold_valid", {31'b0, out_valid}, 32'd1);
    chk("bp_hold_data",  {16'b0, out_data},  32'h0002);
    #1 out_ready = 1'b1;
    @(negedge clk);
    chk("bp_second", {16'b0, out_data}, 32'h0004);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("bp_third", {16'b0, out_data}, 32'h0008);
    @(negedge clk);

    // Flush with both stages full and a new op offered
    @(negedge clk); #1 out_ready = 1'b0; drive_op(OP_SLL, 16'h0001, 4'd1, 3'd0, 1'b0, 3'd1);
    @(negedge clk); #1 drive_op(OP_SLL, 16'h0001, 4'd2, 3'd0, 1'b0, 3'd2);
    @(negedge clk); #1 flush = 1'b1; drive_op(OP_SLL, 16'h0001, 4'd3, 3'd0, 1'b0, 3'd3);
    @(negedge clk);
    chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
    #1 flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("flush_no_accept", {31'b0, out_valid}, 32'd0);

    // Reset with two ops in flight
    @(negedge clk); #1 drive_op(OP_ROR, 16'h1234, 4'd4, 3'd0, 1'b0, 3'd6);
    @(negedge clk); #1 drive_op(OP_SRL, 16'hFFFF, 4'd8, 3'd0, 1'b0, 3'd7);
    @(negedge clk); #1 in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("mrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("mrst_out_data",  {16'b0, out_data},  32'd0);
    chk("mrst_out_rd",    {29'b0, out_rd},    32'd0);
    chk("mrst_in_ready",  {31'b0, in_ready},  32'd1);
    #1 rst = 1'b0;

    // Randomized traffic checked by the model
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      #1;
      in_valid  = ($urandom_range(0, 99) < 70);
      out_ready = ($urandom_range(0, 99) < 75);
      flush     = ($urandom_range(0, 99) < 3);
      rst       = ($urandom_range(0, 199) == 0);
      in_op     = 3'($urandom_range(0, 7));
      in_data   = 16'($urandom);
      in_cnt    = 4'($urandom_range(0, 15));
      in_rs     = 3'($urandom_range(0, 3));
      in_rs_vld = 1'($urandom_range(0, 1));
      in_rd     = 3'($urandom_range(0, 3));
    end

    @(negedge clk); #1 in_valid = 1'b0; flush = 1'b0; rst = 1'b0; out_ready = 1'b1;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_ex_pipe.md
# shift_ex_pipe

Two-stage pipelined execute unit for shift and rotate instructions. It sits between the decode/issue logic and the EX/MEM boundary. It latches decoded shift operands, drives the existing 16-bit barrel `shifter` from a registered operand stage, and captures the result in an output register. Valid/ready handshakes run on both sides, and an optional result-forwarding path resolves back-to-back register dependencies.

## Interface
- No parameters; data width is 16, count width 4, register index width 3.
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `flush`  in  1  synchronous kill of all in-flight ops
- `in_valid`  in  1  upstream op present
- `in_ready`  out  1  stage accepts op this cycle
- `in_op`  in  3  shift opcode (package constants)
- `in_data`  in  16  operand to shift
- `in_cnt`  in  4  shift amount 0..15
- `in_rs`  in  3  source register index of `in_data`
- `in_rs_vld`  in  1  `in_data` comes from a register (forwarding candidate)
- `in_rd`  in  3  destination register index
- `out_valid`  out  1  result present
- `out_ready`  in  1  downstream accepts result
- `out_data`  out  16  shifted result
- `out_rd`  out  3  destination register index of result

## Operation
- S1 (operand register) holds op, data, cnt, rs, rs_vld, rd and a valid bit. S2 (result register) holds data, rd and a valid bit.
- Ready chain (combinational):
  - s2_ready = !s2_valid | out_ready
  - s1_ready = !s1_valid | s2_ready
  - in_ready = s1_ready & !flush
- Accept: `in_valid & in_ready` loads S1. S1→S2 transfer when `s1_valid & s2_ready`; S2 captures the `shifter` output computed from S1 fields.
- Opcodes:
  - ROL 3'b000
  - SLL 3'b001
  - ROR 3'b010
  - SRL 3'b011
  - SRA 3'b100 (sign fill)
  - Codes 101–111 pass data unchanged.
- cnt = 0 passes data unchanged for every op. Logical shifts zero-fill. Rotates wrap modulo 16.
- Transfer ordering is strictly FIFO. No op is dropped or duplicated under backpressure.
- Boundary cases:
  - Flush: both valid bits clear at the edge; flush wins over a simultaneous accept or transfer.
  - Rst: same as flush, and additionally clears `out_data` and `out_rd` to 0.
  - Full pipe with `out_ready=0`: `in_ready=0` and all registers hold.
  - Simultaneous S2 drain and S1 refill in one cycle: allowed, giving full throughput of 1 op/cycle.

## Timing
- Op accepted at edge k. S1 is valid after edge k. `out_valid=1` after edge k+1 if unstalled. Latency is 2 edges; throughput is 1 op/cycle.
- `out_data`/`out_rd` remain stable while `out_valid & !out_ready`.
- Reset values:
  - `in_ready` = 1 once `rst` deasserts (0 during rst cycle only if flush is asserted)
  - `out_valid` = 0
  - `out_data` = 16'h0000
  - `out_rd` = 3'b000
- Reset asserted mid-operation discards all ops by the next edge. There is no partial output.

## Configuration
- Macro `SHIFT_EX_FWD_EN`.
- Defined: shifter input = S2 data when `s1_valid & s1_rs_vld & s2_valid & s1_rs == s2_rd`, else S1 data. This forwards the immediately preceding op's result; older results are the register file's responsibility.
- Undefined: shifter input is always S1 data. Forwarding compare logic is absent.

## Structure
- Package `shift_pkg`: opcode constants (ROL/SLL/ROR/SRL/SRA) and width constants DATA_W=16, CNT_W=4, REG_W=3. The `shifter` op decode uses the same constants.
- Sub-module: existing combinational `shifter` (In, Cnt, Op, Out), one instance fed from S1 (or the forward mux). No other hierarchy.

## Test plan
- Basic ops, out_ready=1:
  - SLL 16'h0001 cnt 15 → 16'h8000
  - SRA 16'h8000 cnt 4 → 16'hF800
  - SRL 16'h8000 cnt 4 → 16'h0800
  - ROR 16'h0001 cnt 1 → 16'h8000
  - each `out_valid` exactly 2 edges after accept
- Backpressure: hold out_ready=0 and issue 3 back-to-back ops.
  - First two ops held; `in_ready`=0 for the third.
  - Release out_ready: results emerge in order, one per cycle.
- Flush: assert flush with S1 and S2 valid plus an in_valid in the same cycle.
  - Next cycle: out_valid=0 and S1 empty; new op not accepted.
- Forwarding: op A = SLL 16'h0003 cnt 2 rd=3; op B issued next cycle = ROL in_data 16'h00F0 cnt 1 rs=3 rs_vld=1.
  - With `SHIFT_EX_FWD_EN`: B → 16'h0018.
  - Without: B → 16'h01E0.
- Reset mid-stream: rst with 2 ops in flight.
  - Next cycle: out_valid=0, out_data=16'h0000, out_rd=0, in_ready=1.
- Unused opcode 3'b111 or cnt 0 with any op: data 16'hA5C3 passes unchanged.
